// File: rtl/fpf_encoder_seq_if.sv
// Handshake bundle between a data source, the FPF encoder and the bus-driver register.
// DATA_WIDTH is derived from CODE_WIDTH the same way the encoder derives it.
interface fpf_encoder_seq_if #(
   parameter int CODE_WIDTH = 7
);

   function automatic int unsigned fibAt(input int k);
      int unsigned a;
      int unsigned b;
      int unsigned t;
      a = 1;
      b = 1;
      for (int i = 3; i <= k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   localparam int DATA_WIDTH = $clog2(fibAt(CODE_WIDTH + 2));

   logic [DATA_WIDTH-1:0] datain;
   logic                  in_valid;
   logic                  in_ready;
   logic [CODE_WIDTH-1:0] codeout;
   logic                  out_valid;
   logic                  out_ready;
   logic                  err;
   logic                  busy;

   modport master (
      output datain, in_valid, out_ready,
      input  in_ready, codeout, out_valid, err, busy
   );

   modport slave (
      input  datain, in_valid, out_ready,
      output in_ready, codeout, out_valid, err, busy
   );

endinterface

// File: rtl/fpf_encoder_seq.sv
// Multi-cycle FPF (Fibonacci, forbidden-pattern-free) CAC encoder: one code bit per clock,
// MSB first, with valid/ready on both sides. CODE_WIDTH is meant for 3..24.
module fpf_encoder_seq #(
   parameter int CODE_WIDTH = 7
) (
   input  logic               clock,
   input  logic               rst_n,
   fpf_encoder_seq_if.slave   io_bus
);

   function automatic int unsigned fibAt(input int k);
      int unsigned a;
      int unsigned b;
      int unsigned t;
      a = 1;
      b = 1;
      for (int i = 3; i <= k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return b;
   endfunction

   localparam int                    DATA_WIDTH = $clog2(fibAt(CODE_WIDTH + 2));
   localparam int                    K_WIDTH    = $clog2(CODE_WIDTH);
   localparam int unsigned           FIB_TOP    = fibAt(CODE_WIDTH + 2);
   localparam logic [DATA_WIDTH-1:0] SAT_VALUE  = DATA_WIDTH'(FIB_TOP - 1);
   localparam logic [K_WIDTH-1:0]    K_START    = K_WIDTH'(CODE_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_stateNext;
   logic [DATA_WIDTH-1:0]   r_rem;
   logic                    r_prev;
   logic [K_WIDTH-1:0]      r_k;
   logic [CODE_WIDTH-1:1]   r_work;
   logic                    r_errPend;
   logic [CODE_WIDTH-1:0]   r_code;
   logic                    r_err;

   logic [DATA_WIDTH-1:0]   w_fibLo [1:CODE_WIDTH-1];
   logic [DATA_WIDTH-1:0]   w_fibHi [1:CODE_WIDTH-1];
   logic [DATA_WIDTH-1:0]   w_lo;
   logic [DATA_WIDTH-1:0]   w_hi;
   logic                    w_bit;
   logic [DATA_WIDTH-1:0]   w_remNext;
   logic [CODE_WIDTH-1:1]   w_workNext;
   logic                    w_lastBit;
   logic                    w_inRange;
   logic [DATA_WIDTH-1:0]   w_clamped;
   logic                    w_inReady;
   logic                    w_busy;
   logic                    w_outValid;

   // Per-bit weights: bit k weighs F(k+1); F(k+2) is the threshold that forces a 1.
   for (genvar gk = 1; gk < CODE_WIDTH; gk++) begin : g_fib
      assign w_fibLo[gk] = DATA_WIDTH'(fibAt(gk + 1));
      assign w_fibHi[gk] = DATA_WIDTH'(fibAt(gk + 2));
   end

   always_comb begin
      w_lo       = '0;
      w_hi       = '0;
      w_workNext = r_work;
      for (int i = 1; i < CODE_WIDTH; i++) begin
         if (r_k == K_WIDTH'(i)) begin
            w_lo = w_fibLo[i];
            w_hi = w_fibHi[i];
         end
      end

      // Remainder inside [F(k+1), F(k+2)) can go either way; copying the previous bit
      // is what keeps 010 and 101 out of the codeword.
      if (r_rem < w_lo) begin
         w_bit = 1'b0;
      end else if (r_rem >= w_hi) begin
         w_bit = 1'b1;
      end else begin
         w_bit = r_prev;
      end

      w_remNext = w_bit ? (r_rem - w_lo) : r_rem;
      for (int i = 1; i < CODE_WIDTH; i++) begin
         if (r_k == K_WIDTH'(i)) begin
            w_workNext[i] = w_bit;
         end
      end
      w_lastBit = (r_k == K_WIDTH'(1));

      w_inRange = (32'(io_bus.datain) < FIB_TOP);
      w_clamped = w_inRange ? io_bus.datain : SAT_VALUE;
   end

   always_comb begin
      w_stateNext = r_state;
      w_inReady   = 1'b0;
      w_busy      = 1'b0;
      w_outValid  = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_inReady = 1'b1;
            if (io_bus.in_valid) begin
               w_stateNext = BUSY;
            end
         end
         BUSY: begin
            w_busy = 1'b1;
            if (w_lastBit) begin
               w_stateNext = DONE;
            end
         end
         DONE: begin
            w_outValid = 1'b1;
            if (io_bus.out_ready) begin
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // codeout/err only change on the final bit edge, so they hold the last result
   // through IDLE and the next BUSY phase.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_rem     <= '0;
         r_prev    <= 1'b0;
         r_k       <= '0;
         r_work    <= '0;
         r_errPend <= 1'b0;
         r_code    <= '0;
         r_err     <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (io_bus.in_valid) begin
                  r_rem     <= w_clamped;
                  r_errPend <= ~w_inRange;
                  r_prev    <= 1'b0;
                  r_k       <= K_START;
                  r_work    <= '0;
               end
            end
            BUSY: begin
               r_rem  <= w_remNext;
               r_prev <= w_bit;
               r_k    <= r_k - K_WIDTH'(1);
               r_work <= w_workNext;
               if (w_lastBit) begin
                  r_code <= {w_workNext, w_remNext[0]};
                  r_err  <= r_errPend;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign io_bus.in_ready  = w_inReady;
   assign io_bus.busy      = w_busy;
   assign io_bus.out_valid = w_outValid;
   assign io_bus.codeout   = r_code;
   assign io_bus.err       = r_err;

endmodule
